// File: rtl/uart_pixel_packer_pkg.sv
// Shared types and constants for the UART pixel packer.
//   state_t       : byte-phase FSM encoding (R, G, B, frame done)
//   DEF_*         : default geometry / channel depth
//   pix_w()       : packed pixel width for a given channel depth
//   frame_pix()   : pixel count of a frame
package uart_pixel_packer_pkg;

    typedef enum logic [1:0] {
        S_R    = 2'd0,
        S_G    = 2'd1,
        S_B    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_IMG_W     = 160;
    localparam int unsigned DEF_IMG_H     = 120;
    localparam int unsigned DEF_CH_BITS   = 4;
    localparam int unsigned DEF_PIX_W     = 3 * DEF_CH_BITS;
    localparam int unsigned DEF_FRAME_PIX = DEF_IMG_W * DEF_IMG_H;

    function automatic int unsigned pix_w(input int unsigned ch_bits);
        return 3 * ch_bits;
    endfunction

    function automatic int unsigned frame_pix(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/uart_pixel_packer_if.sv
// Frame-buffer write port bundle.
//   wr_en      : one-cycle RAM write strobe
//   wr_addr    : raster-order write address
//   wr_data    : packed {R,G,B} pixel
//   frame_done : level, high once the last pixel of the frame is written
// master = pixel packer (drives), slave = frame-buffer RAM / VGA side.
interface uart_pixel_packer_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned PIX_W  = uart_pixel_packer_pkg::DEF_PIX_W
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              frame_done;

    modport master (output wr_en, output wr_addr, output wr_data, output frame_done);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  frame_done);
endinterface

// File: rtl/uart_pixel_packer_pulse_stretch.sv
// Retriggerable pulse stretcher for status LEDs.
//   clk, rst_n : clock, async active-low reset
//   trig       : reload strobe
//   pulse      : high for CLKS cycles after the most recent trig
module uart_pixel_packer_pulse_stretch #(
    parameter int unsigned CLKS = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic pulse
);
    localparam int unsigned CNT_W = $clog2(CLKS + 1);

    logic [CNT_W-1:0] cnt;

    // Output covers the trig cycle plus CLKS-1 counted cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            if (trig) begin
                cnt <= CNT_W'(CLKS - 1);
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            pulse <= trig | (cnt != '0);
        end
    end
endmodule

// File: rtl/uart_pixel_packer.sv
// Packs UART bytes into R,G,B pixels and writes them to the frame buffer.
//   i_Clock, i_Rst_n : clock, async active-low reset
//   i_Clear          : synchronous restart of the frame
//   i_Rx_DV, i_Rx_Byte : byte stream from the UART receiver
//   wr               : frame-buffer write port (strobe, address, data, frame done)
//   o_Sync_Err       : one-cycle pulse when a partial pixel is discarded
//   o_Led            : activity LED
module uart_pixel_packer
    import uart_pixel_packer_pkg::*;
#(
    parameter int unsigned IMG_W        = DEF_IMG_W,
    parameter int unsigned IMG_H        = DEF_IMG_H,
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned CH_BITS      = DEF_CH_BITS,
    parameter int unsigned TIMEOUT_CLKS = 87 * 30,
    parameter int unsigned LED_CLKS     = 1000000
) (
    input  logic                i_Clock,
    input  logic                i_Rst_n,
    input  logic                i_Clear,
    input  logic                i_Rx_DV,
    input  logic [7:0]          i_Rx_Byte,
    uart_pixel_packer_if.master wr,
    output logic                o_Sync_Err,
    output logic                o_Led
);
    localparam int unsigned PIX_W    = pix_w(CH_BITS);
    localparam int unsigned LAST_PIX = frame_pix(IMG_W, IMG_H) - 1;
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_PIX);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);

    state_t              state_q, state_d;
    logic [CH_BITS-1:0]  r_q, r_d, g_q, g_d;
    logic [TO_W-1:0]     to_q, to_d, to_inc;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [PIX_W-1:0]    data_q, data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                partial_c, expire_c;
    logic [CH_BITS-1:0]  msb_c;
    logic [7:0]          unused_byte;

    // Only the channel MSBs are kept; the rest of the byte is intentionally dropped.
    assign unused_byte = i_Rx_Byte;
    assign msb_c       = i_Rx_Byte[7 -: CH_BITS];

    assign to_inc    = to_q + TO_W'(1);
    assign partial_c = (state_q == S_G) || (state_q == S_B);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign expire_c  = partial_c && !i_Rx_DV && (to_inc == TO_LAST);

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        g_d     = g_q;
        to_d    = to_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        err_d   = 1'b0;

        // Address steps the cycle after a strobe, except after the final pixel.
        if (wr_en_q && !done_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            S_R: begin
                to_d = '0;
                if (i_Rx_DV) begin
                    r_d     = msb_c;
                    state_d = S_G;
                end
            end
            S_G: begin
                if (i_Rx_DV) begin
                    g_d     = msb_c;
                    to_d    = '0;
                    state_d = S_B;
                end else if (expire_c) begin
                    to_d    = '0;
                    err_d   = 1'b1;
                    state_d = S_R;
                end else begin
                    to_d = to_inc;
                end
            end
            S_B: begin
                if (i_Rx_DV) begin
                    data_d  = {r_q, g_q, msb_c};
                    wr_en_d = 1'b1;
                    to_d    = '0;
                    if (addr_q == LAST_ADDR) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_R;
                    end
                end else if (expire_c) begin
                    to_d    = '0;
                    err_d   = 1'b1;
                    state_d = S_R;
                end else begin
                    to_d = to_inc;
                end
            end
            S_DONE: begin
                to_d = '0;
            end
            default: begin
                to_d    = '0;
                state_d = S_R;
            end
        endcase

        // Restart drops any partial pixel and same-cycle byte; an in-flight strobe still completes.
        if (i_Clear) begin
            state_d = S_R;
            to_d    = '0;
            wr_en_d = 1'b0;
            addr_d  = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= S_R;
            r_q     <= '0;
            g_q     <= '0;
            to_q    <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            g_q     <= g_d;
            to_q    <= to_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wr.wr_en      = wr_en_q;
    assign wr.wr_addr    = addr_q;
    assign wr.wr_data    = data_q;
    assign wr.frame_done = done_q;
    assign o_Sync_Err    = err_q;

    uart_pixel_packer_pulse_stretch #(
        .CLKS (LED_CLKS)
    ) u_led (
        .clk   (i_Clock),
        .rst_n (i_Rst_n),
        .trig  (i_Rx_DV),
        .pulse (o_Led)
    );
endmodule

// File: tb/tb_uart_pixel_packer.sv
// Directed bench for uart_pixel_packer with a 4x2 frame.
module tb_uart_pixel_packer;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned PIX_W  = 12;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       dv;
    logic [7:0] rx_byte;
    logic       sync_err;
    logic       led;

    int vectors;
    int misses;

    uart_pixel_packer_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) wr_bus ();

    uart_pixel_packer #(
        .IMG_W        (4),
        .IMG_H        (2),
        .ADDR_W       (ADDR_W),
        .CH_BITS      (4),
        .TIMEOUT_CLKS (20),
        .LED_CLKS     (8)
    ) dut (
        .i_Clock    (clk),
        .i_Rst_n    (rst_n),
        .i_Clear    (clear),
        .i_Rx_DV    (dv),
        .i_Rx_Byte  (rx_byte),
        .wr         (wr_bus),
        .o_Sync_Err (sync_err),
        .o_Led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; byte is sampled on the next rising edge, returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        dv      = 1'b1;
        rx_byte = b;
        @(negedge clk);
        dv      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        misses  = 0;
        rst_n   = 1'b0;
        clear   = 1'b0;
        dv      = 1'b0;
        rx_byte = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(wr_bus.wr_en), 32'd0);
        check("rst_addr", 32'(wr_bus.wr_addr), 32'd0);
        check("rst_data", 32'(wr_bus.wr_data), 32'd0);
        check("rst_done", 32'(wr_bus.frame_done), 32'd0);
        check("rst_err", 32'(sync_err), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // First pixel, 5-clock byte spacing
        send_byte(8'hF0);
        idle(4);
        send_byte(8'h80);
        idle(4);
        check("p0_no_early_wr", 32'(wr_bus.wr_en), 32'd0);
        send_byte(8'h1F);
        check("p0_wr_en", 32'(wr_bus.wr_en), 32'd1);
        check("p0_addr", 32'(wr_bus.wr_addr), 32'd0);
        check("p0_data", 32'(wr_bus.wr_data), 32'hF81);
        idle(1);
        check("p0_wr_en_1cyc", 32'(wr_bus.wr_en), 32'd0);
        check("p0_addr_inc", 32'(wr_bus.wr_addr), 32'd1);
        idle(4);

        // Partial pixel then idle: single error pulse 19 clocks after the last byte
        send_byte(8'h11);
        idle(2);
        send_byte(8'h22);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            check($sformatf("sync_err_k%0d", k), 32'(sync_err), 32'(k == 19));
        end
        check("sync_addr_hold", 32'(wr_bus.wr_addr), 32'd1);
        send_byte(8'hAB);
        idle(2);
        send_byte(8'hCD);
        idle(2);
        send_byte(8'hEF);
        check("resync_wr_en", 32'(wr_bus.wr_en), 32'd1);
        check("resync_addr", 32'(wr_bus.wr_addr), 32'd1);
        check("resync_data", 32'(wr_bus.wr_data), 32'hACE);
        idle(1);
        check("resync_addr_inc", 32'(wr_bus.wr_addr), 32'd2);

        // Restart and fill a whole frame
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_addr", 32'(wr_bus.wr_addr), 32'd0);
        for (int p = 0; p < 8; p++) begin
            send_byte(8'(p * 16));
            idle(1);
            send_byte(8'((7 - p) * 16 + 5));
            idle(1);
            send_byte(8'h3C);
            check($sformatf("frm_wr_en_%0d", p), 32'(wr_bus.wr_en), 32'd1);
            check($sformatf("frm_addr_%0d", p), 32'(wr_bus.wr_addr), 32'(p));
            check($sformatf("frm_data_%0d", p), 32'(wr_bus.wr_data),
                  32'((p << 8) | ((7 - p) << 4) | 3));
            check($sformatf("frm_done_%0d", p), 32'(wr_bus.frame_done), 32'(p == 7));
            idle(2);
        end
        check("frm_end_wr_en", 32'(wr_bus.wr_en), 32'd0);
        check("frm_end_addr", 32'(wr_bus.wr_addr), 32'd7);
        check("frm_end_done", 32'(wr_bus.frame_done), 32'd1);
        for (int e = 0; e < 3; e++) begin
            send_byte(8'hA5);
            check($sformatf("done_no_wr_%0d", e), 32'(wr_bus.wr_en), 32'd0);
            idle(1);
            check($sformatf("done_hold_%0d", e), 32'(wr_bus.frame_done), 32'd1);
        end
        check("done_led", 32'(led), 32'd1);

        // Clear together with a byte: byte dropped, frame restarts at 0
        clear   = 1'b1;
        dv      = 1'b1;
        rx_byte = 8'h55;
        @(negedge clk);
        clear = 1'b0;
        dv    = 1'b0;
        check("clr_done", 32'(wr_bus.frame_done), 32'd0);
        check("clr_addr", 32'(wr_bus.wr_addr), 32'd0);
        check("clr_wr_en", 32'(wr_bus.wr_en), 32'd0);
        idle(1);
        send_byte(8'h12);
        idle(1);
        send_byte(8'h34);
        idle(1);
        send_byte(8'h56);
        check("clr_px_wr_en", 32'(wr_bus.wr_en), 32'd1);
        check("clr_px_addr", 32'(wr_bus.wr_addr), 32'd0);
        check("clr_px_data", 32'(wr_bus.wr_data), 32'h135);
        check("clr_px_done", 32'(wr_bus.frame_done), 32'd0);
        idle(2);
        check("clr_px_addr_inc", 32'(wr_bus.wr_addr), 32'd1);

        // Asynchronous reset in the middle of a pixel
        send_byte(8'h90);
        idle(1);
        check("pre_rst_led", 32'(led), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wr_en", 32'(wr_bus.wr_en), 32'd0);
        check("arst_addr", 32'(wr_bus.wr_addr), 32'd0);
        check("arst_data", 32'(wr_bus.wr_data), 32'd0);
        check("arst_done", 32'(wr_bus.frame_done), 32'd0);
        check("arst_err", 32'(sync_err), 32'd0);
        check("arst_led", 32'(led), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send_byte(8'h20);
        idle(1);
        send_byte(8'h40);
        idle(1);
        send_byte(8'h60);
        check("post_rst_wr_en", 32'(wr_bus.wr_en), 32'd1);
        check("post_rst_addr", 32'(wr_bus.wr_addr), 32'd0);
        check("post_rst_data", 32'(wr_bus.wr_data), 32'h246);

        // LED stretch: single byte
        idle(12);
        check("led_idle", 32'(led), 32'd0);
        send_byte(8'h07);
        check("led_single_0", 32'(led), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("led_single_%0d", k), 32'(led), 32'(k <= 7));
        end

        // LED retrigger: second byte five clocks after the first
        idle(3);
        send_byte(8'h08);
        idle(4);
        send_byte(8'h09);
        check("led_retrig_0", 32'(led), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("led_retrig_%0d", k), 32'(led), 32'(k <= 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
